acc_unit: RTL and testbench

- Execution unit directly downstream of the single-entry accumulate reservation station.
- Consumes confirmed accumulate operands over the acc_req valid/ready handshake and adds each into an architectural FP accumulator register.
- Serves "get" requests: reads the accumulator, broadcasts it on the FP CDB with a ROB tag, then clears it.
- Addition uses the team's shared pipelined fadd core.

---
 rtl/acc_unit_pkg.sv | 14 +
 rtl/acc_unit_fadd.sv | 98 +++++++++
 rtl/acc_unit.sv | 97 +++++++++
 tb/tb_acc_unit.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/acc_unit_pkg.sv
// Shared types for the FP accumulate unit: CDB broadcast record, ROB tag width,
// fadd pipeline depth and the accumulate FSM state encoding.
package acc_unit_pkg;
   localparam int ROB_WIDTH    = 6;
   localparam int FADD_LATENCY = 3;

   typedef struct packed {
      logic                 valid;
      logic [ROB_WIDTH-1:0] tag;
      logic [31:0]          data;
   } cdb_t;

   typedef enum logic [1:0] {IDLE, ADD, OUT} acc_state_t;
endpackage

// File: rtl/acc_unit_fadd.sv
// Single-precision adder, round-to-nearest-even, denormals flushed to zero.
// Result appears LATENCY cycles after in_vld; no stall, the pipeline always advances.
module acc_unit_fadd #(
   parameter int LATENCY = 3
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_vld,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        out_vld,
   output logic [31:0] sum
);
   logic              a_big, sa, sb, found;
   logic [7:0]        ea, eb, d;
   logic [22:0]       fa;
   logic [23:0]       ma, mb;
   logic [26:0]       mx, my, n;
   logic [27:0]       s;
   logic [4:0]        lz;
   logic signed [9:0] e;
   logic [24:0]       r;
   logic [31:0]       res;

   always_comb begin
      a_big = a[30:0] >= b[30:0];
      sa    = a_big ? a[31]    : b[31];
      ea    = a_big ? a[30:23] : b[30:23];
      fa    = a_big ? a[22:0]  : b[22:0];
      sb    = a_big ? b[31]    : a[31];
      eb    = a_big ? b[30:23] : a[30:23];
      ma    = (ea == 8'd0) ? 24'd0 : {1'b1, fa};
      mb    = (eb == 8'd0) ? 24'd0 : {1'b1, (a_big ? b[22:0] : a[22:0])};
      d     = ea - eb;
      mx    = {ma, 3'b000};
      // Bits shifted past the guard/round positions collapse into the sticky bit.
      if (d >= 8'd27)
         my = {26'd0, |mb};
      else
         my = ({mb, 3'b000} >> d) | {26'd0, |({mb, 3'b000} & ~(27'h7FFFFFF << d))};
      if (sa == sb)
         s = {1'b0, mx} + {1'b0, my};
      else
         s = {1'b0, mx} - {1'b0, my};
      e     = {2'b00, ea};
      lz    = 5'd0;
      found = 1'b0;
      if (s[27]) begin
         n = s[27:1] | {26'd0, s[0]};
         e = e + 10'sd1;
      end else begin
         for (int i = 26; i >= 0; i--) begin
            if (!found) begin
               if (s[i]) found = 1'b1;
               else      lz = lz + 5'd1;
            end
         end
         n = s[26:0] << lz;
         e = e - $signed({5'd0, lz});
      end
      r = {1'b0, n[26:3]} + {24'd0, n[2] & (n[1] | n[0] | n[3])};
      if (r[24]) begin
         r = r >> 1;
         e = e + 10'sd1;
      end
      if (ea == 8'hFF) begin
         if (fa != 23'd0 || (eb == 8'hFF && sa != sb)) res = 32'h7FC0_0000;
         else                                           res = {sa, 8'hFF, 23'd0};
      end else if (!r[23])
         res = {sa & (sa == sb), 31'd0};      // exact cancellation gives +0
      else if (e >= 10'sd255)
         res = {sa, 8'hFF, 23'd0};
      else if (e <= 10'sd0)
         res = {sa, 31'd0};
      else
         res = {sa, e[7:0], r[22:0]};
   end

   logic [LATENCY-1:0] vld_q;
   logic [31:0]        sum_q [LATENCY];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q <= '0;
         for (int i = 0; i < LATENCY; i++) sum_q[i] <= '0;
      end else begin
         vld_q[0] <= in_vld;
         sum_q[0] <= res;
         for (int i = 1; i < LATENCY; i++) begin
            vld_q[i] <= vld_q[i-1];
            sum_q[i] <= sum_q[i-1];
         end
      end
   end

   assign out_vld = vld_q[LATENCY-1];
   assign sum     = sum_q[LATENCY-1];
endmodule

// File: rtl/acc_unit.sv
// FP accumulate execution unit: adds confirmed operands into acc_reg and broadcasts/clears it on a get.
// Accumulate takes FADD_LATENCY+1 cycles; both readies drop while adding, a get holds OUT until the CDB grant.
import acc_unit_pkg::*;

module acc_unit (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 acc_req_valid,
   output logic                 acc_req_ready,
   input  logic [31:0]          acc_data,
   input  logic                 get_req_valid,
   output logic                 get_req_ready,
   input  logic [ROB_WIDTH-1:0] get_tag,
   output logic                 cdb_req_valid,
   input  logic                 cdb_req_ready,
   output cdb_t                 cdb_out,
   input  logic                 failure,
   output logic                 busy
);
   localparam int CNT_W = (FADD_LATENCY > 1) ? $clog2(FADD_LATENCY) : 1;

   acc_state_t           state, state_nxt;
   logic [31:0]          acc_reg, acc_nxt, fadd_sum;
   logic [ROB_WIDTH-1:0] out_tag, tag_nxt;
   logic [CNT_W-1:0]     cnt, cnt_nxt;
   logic                 fadd_in_vld, fadd_out_vld;

   acc_unit_fadd #(.LATENCY(FADD_LATENCY)) u_fadd (
      .clk     (clk),
      .rst_n   (rst_n),
      .in_vld  (fadd_in_vld),
      .a       (acc_reg),
      .b       (acc_data),
      .out_vld (fadd_out_vld),
      .sum     (fadd_sum)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         acc_reg <= 32'h0;
         out_tag <= '0;
         cnt     <= '0;
      end else begin
         state   <= state_nxt;
         acc_reg <= acc_nxt;
         out_tag <= tag_nxt;
         cnt     <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      acc_nxt       = acc_reg;
      tag_nxt       = out_tag;
      cnt_nxt       = cnt;
      fadd_in_vld   = 1'b0;
      acc_req_ready = 1'b0;
      get_req_ready = 1'b0;
      cdb_req_valid = 1'b0;
      unique case (state)
         IDLE: begin
            acc_req_ready = 1'b1;
            get_req_ready = !acc_req_valid;
            if (acc_req_valid) begin
               fadd_in_vld = 1'b1;
               cnt_nxt     = CNT_W'(FADD_LATENCY - 1);
               state_nxt   = ADD;
            end else if (get_req_valid && !failure) begin
               tag_nxt   = get_tag;
               state_nxt = OUT;
            end
         end
         ADD: begin
            // Operands are already confirmed, so a flush never cancels the add.
            if (cnt != '0) cnt_nxt = cnt - 1'b1;
            if (cnt == '0 && fadd_out_vld) begin
               acc_nxt   = fadd_sum;
               state_nxt = IDLE;
            end
         end
         OUT: begin
            cdb_req_valid = 1'b1;
            if (cdb_req_ready) begin
               acc_nxt   = 32'h0;
               state_nxt = IDLE;
            end else if (failure) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign cdb_out = '{valid: cdb_req_valid && cdb_req_ready, tag: out_tag, data: acc_reg};
   assign busy    = (state != IDLE);
endmodule

// File: tb/tb_acc_unit.sv
// Bench for acc_unit: directed scenarios plus randomized integer-valued accumulates
// checked against an exact integer model of the accumulator.
import acc_unit_pkg::*;

module tb_acc_unit;
   logic                 clk = 1'b0;
   logic                 rst_n;
   logic                 acc_req_valid, acc_req_ready;
   logic [31:0]          acc_data;
   logic                 get_req_valid, get_req_ready;
   logic [ROB_WIDTH-1:0] get_tag;
   logic                 cdb_req_valid, cdb_req_ready;
   cdb_t                 cdb_out;
   logic                 failure, busy;

   int checks = 0;
   int errors = 0;
   int m_acc  = 0;

   always #5 clk = ~clk;

   acc_unit dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .acc_req_valid (acc_req_valid),
      .acc_req_ready (acc_req_ready),
      .acc_data      (acc_data),
      .get_req_valid (get_req_valid),
      .get_req_ready (get_req_ready),
      .get_tag       (get_tag),
      .cdb_req_valid (cdb_req_valid),
      .cdb_req_ready (cdb_req_ready),
      .cdb_out       (cdb_out),
      .failure       (failure),
      .busy          (busy)
   );

   // Exact single-precision encoding of an integer with magnitude below 2^24.
   function automatic logic [31:0] i2f(input int v);
      int   m, p;
      logic sgn;
      if (v == 0) return 32'h0;
      sgn = (v < 0);
      m   = sgn ? -v : v;
      p   = 0;
      while ((m >> (p + 1)) != 0) p++;
      return {sgn, 8'(127 + p), 23'((m << (23 - p)) & 32'h7F_FFFF)};
   endfunction

   task automatic wait_ready(input bit is_get);
      int n = 0;
      while ((is_get ? get_req_ready : acc_req_ready) !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) begin
         checks++; errors++;
         $display("FAIL ready_timeout is_get=%0d waited %0d cycles", is_get, n);
      end
   endtask

   task automatic do_acc(input int v);
      wait_ready(1'b0);
      acc_req_valid = 1'b1;
      acc_data      = i2f(v);
      @(negedge clk);
      acc_req_valid = 1'b0;
      m_acc += v;
   endtask

   task automatic do_get(input logic [ROB_WIDTH-1:0] tag, input int hold,
                         output logic o_vld, output logic [ROB_WIDTH-1:0] o_tag,
                         output logic [31:0] o_data);
      wait_ready(1'b1);
      get_req_valid = 1'b1;
      get_tag       = tag;
      @(negedge clk);
      get_req_valid = 1'b0;
      repeat (hold) @(negedge clk);
      cdb_req_ready = 1'b1;
      #1;
      o_vld  = cdb_out.valid;
      o_tag  = cdb_out.tag;
      o_data = cdb_out.data;
      @(negedge clk);
      cdb_req_ready = 1'b0;
   endtask

   task automatic test_reset;
      logic v; logic [ROB_WIDTH-1:0] t; logic [31:0] d;
      rst_n = 1'b0;
      acc_req_valid = 0; get_req_valid = 0; cdb_req_ready = 0; failure = 0;
      acc_data = '0; get_tag = '0;
      repeat (2) @(negedge clk);
      checks++;
      if ({acc_req_ready, get_req_ready, cdb_req_valid, busy, cdb_out.valid} !== 5'b11000) begin
         errors++;
         $display("FAIL reset_outputs got %b want 11000",
                  {acc_req_ready, get_req_ready, cdb_req_valid, busy, cdb_out.valid});
      end
      rst_n = 1'b1;
      @(negedge clk);
      do_get(6'd5, 1, v, t, d);
      checks++;
      if (v !== 1'b1 || t !== 6'd5 || d !== 32'h0) begin
         errors++;
         $display("FAIL reset_get got v=%b tag=%0d data=%h want v=1 tag=5 data=00000000", v, t, d);
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++; $display("FAIL reset_get_idle busy=%b want 0", busy);
      end
   endtask

   task automatic test_accumulate;
      logic v; logic [ROB_WIDTH-1:0] t; logic [31:0] d;
      int low = 0;
      wait_ready(1'b0);
      acc_req_valid = 1'b1;
      acc_data      = 32'h3F80_0000;
      @(negedge clk);
      acc_data = 32'h4000_0000;
      checks++;
      if (busy !== 1'b1) begin
         errors++; $display("FAIL acc_busy busy=%b want 1", busy);
      end
      while (acc_req_ready !== 1'b1 && low < 20) begin
         low++;
         @(negedge clk);
      end
      checks++;
      if (low != FADD_LATENCY) begin
         errors++; $display("FAIL acc_ready_low_cycles got %0d want %0d", low, FADD_LATENCY);
      end
      @(negedge clk);
      acc_req_valid = 1'b0;
      m_acc = 3;
      do_get(6'd9, 0, v, t, d);
      checks++;
      if (v !== 1'b1 || t !== 6'd9 || d !== 32'h4040_0000) begin
         errors++;
         $display("FAIL acc_sum got v=%b tag=%0d data=%h want v=1 tag=9 data=40400000", v, t, d);
      end
      m_acc = 0;
   endtask

   task automatic test_tie;
      int n = 0;
      acc_req_valid = 1'b1; acc_data = 32'h3F80_0000;
      get_req_valid = 1'b1; get_tag = 6'd3;
      #1;
      checks++;
      if (acc_req_ready !== 1'b1 || get_req_ready !== 1'b0) begin
         errors++;
         $display("FAIL tie_readies got acc=%b get=%b want acc=1 get=0", acc_req_ready, get_req_ready);
      end
      @(negedge clk);
      acc_req_valid = 1'b0;
      while (get_req_ready !== 1'b1 && n < 20) begin
         n++;
         @(negedge clk);
      end
      checks++;
      if (n != FADD_LATENCY) begin
         errors++; $display("FAIL tie_get_stall got %0d want %0d", n, FADD_LATENCY);
      end
      @(negedge clk);
      get_req_valid = 1'b0;
      cdb_req_ready = 1'b1;
      #1;
      checks++;
      if (cdb_out.valid !== 1'b1 || cdb_out.tag !== 6'd3 || cdb_out.data !== 32'h3F80_0000) begin
         errors++;
         $display("FAIL tie_broadcast got v=%b tag=%0d data=%h want v=1 tag=3 data=3f800000",
                  cdb_out.valid, cdb_out.tag, cdb_out.data);
      end
      @(negedge clk);
      cdb_req_ready = 1'b0;
      m_acc = 0;
   endtask

   task automatic test_failure_out;
      logic v; logic [ROB_WIDTH-1:0] t; logic [31:0] d;
      int bad = 0;
      do_acc(7);
      wait_ready(1'b1);
      get_req_valid = 1'b1; get_tag = 6'd4;
      @(negedge clk);
      get_req_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (cdb_req_valid !== 1'b1 || cdb_out.valid !== 1'b0) bad++;
         @(negedge clk);
      end
      checks++;
      if (bad != 0) begin
         errors++; $display("FAIL out_wait got %0d bad cycles want 0", bad);
      end
      failure = 1'b1;
      #1;
      checks++;
      if (cdb_out.valid !== 1'b0) begin
         errors++; $display("FAIL out_flush_valid got %b want 0", cdb_out.valid);
      end
      @(negedge clk);
      failure = 1'b0;
      checks++;
      if (busy !== 1'b0 || cdb_req_valid !== 1'b0) begin
         errors++; $display("FAIL out_flush_idle busy=%b cdb_req_valid=%b want 0 0", busy, cdb_req_valid);
      end
      do_get(6'd2, 0, v, t, d);
      checks++;
      if (v !== 1'b1 || t !== 6'd2 || d !== i2f(m_acc)) begin
         errors++;
         $display("FAIL out_flush_keep got v=%b tag=%0d data=%h want v=1 tag=2 data=%h", v, t, d, i2f(m_acc));
      end
      m_acc = 0;
   endtask

   task automatic test_failure_add;
      logic v; logic [ROB_WIDTH-1:0] t; logic [31:0] d;
      do_acc(1);
      failure = 1'b1;
      repeat (FADD_LATENCY) @(negedge clk);
      failure = 1'b0;
      // A get issued alongside a flush in IDLE must be dropped.
      wait_ready(1'b1);
      get_req_valid = 1'b1; get_tag = 6'd7; failure = 1'b1;
      @(negedge clk);
      get_req_valid = 1'b0; failure = 1'b0;
      checks++;
      if (busy !== 1'b0 || cdb_req_valid !== 1'b0) begin
         errors++; $display("FAIL idle_flush_get busy=%b cdb_req_valid=%b want 0 0", busy, cdb_req_valid);
      end
      do_get(6'd11, 0, v, t, d);
      checks++;
      if (v !== 1'b1 || t !== 6'd11 || d !== 32'h3F80_0000) begin
         errors++;
         $display("FAIL add_flush_commit got v=%b tag=%0d data=%h want v=1 tag=11 data=3f800000", v, t, d);
      end
      m_acc = 0;
   endtask

   task automatic test_reset_mid_add;
      logic v; logic [ROB_WIDTH-1:0] t; logic [31:0] d;
      do_acc(5);
      rst_n = 1'b0;
      #1;
      checks++;
      if ({acc_req_ready, busy, cdb_req_valid} !== 3'b100) begin
         errors++;
         $display("FAIL reset_mid_add got %b want 100", {acc_req_ready, busy, cdb_req_valid});
      end
      @(negedge clk);
      rst_n = 1'b1;
      m_acc = 0;
      @(negedge clk);
      do_get(6'd1, 0, v, t, d);
      checks++;
      if (v !== 1'b1 || d !== 32'h0) begin
         errors++; $display("FAIL reset_mid_add_get got v=%b data=%h want v=1 data=00000000", v, d);
      end
   endtask

   task automatic test_random;
      logic v; logic [ROB_WIDTH-1:0] t, tag; logic [31:0] d;
      int nacc, val, hold;
      for (int r = 0; r < 12; r++) begin
         nacc = $urandom_range(1, 4);
         for (int k = 0; k < nacc; k++) begin
            val = int'($urandom_range(0, 2000)) - 1000;
            do_acc(val);
         end
         tag  = ROB_WIDTH'($urandom_range(0, 63));
         hold = $urandom_range(0, 3);
         do_get(tag, hold, v, t, d);
         checks++;
         if (v !== 1'b1 || t !== tag || d !== i2f(m_acc)) begin
            errors++;
            $display("FAIL random_get round=%0d got v=%b tag=%0d data=%h want v=1 tag=%0d data=%h",
                     r, v, t, d, tag, i2f(m_acc));
         end
         m_acc = 0;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not complete");
      $fatal(1);
   end

   initial begin
      test_reset;
      test_accumulate;
      test_tie;
      test_failure_out;
      test_failure_add;
      test_reset_mid_add;
      test_random;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
